// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry, colors and redraw FSM encoding
//
// Purpose: constants shared by the board scanner and redraw sequencer.
// Ports: none (package).
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int CELL_W  = 64;
  localparam int CELL_H  = 24;

  // RGB 3:3:3
  localparam logic [8:0] COLOR_FILL = 9'b111_000_111;
  localparam logic [8:0] COLOR_BG   = 9'b000_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_CHECK,
    ST_KICK,
    ST_PAINT,
    ST_FIN
  } redraw_state_t;

endpackage

// File: rtl/board_scan_counter.sv
// rtl/board_scan_counter.sv - row-major x/y cell address counter for the board scan
//
// Purpose: walks x=0..9 inside y=0..19 and flags the final cell.
// Ports:
//   CLOCK_50, resetn : clock, asynchronous active-low reset
//   clr              : synchronous return to (0,0)
//   adv              : step to the next cell (ignored on the last cell)
//   x, y             : current cell address
//   last             : high while the address is (9,19)
module board_scan_counter
  import tetris_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       clr,
  input  logic       adv,
  output logic [3:0] x,
  output logic [4:0] y,
  output logic       last
);

  assign last = (x == 4'(BOARD_W - 1)) && (y == 5'(BOARD_H - 1));

  // The final cell holds its address so row 20 is never presented.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (adv && !last) begin
      if (x == 4'(BOARD_W - 1)) begin
        x <= '0;
        y <= y + 5'd1;
      end else begin
        x <= x + 4'd1;
      end
    end
  end

endmodule

// File: rtl/board_redraw.sv
// rtl/board_redraw.sv - repaints every board cell through the box painter handshake
//
// Purpose: scans the 10x20 board RAM and kicks the painter once per drawn cell.
// Ports:
//   CLOCK_50, resetn            : clock, asynchronous active-low reset
//   start                       : one-cycle request for a full repaint
//   board_rdata                 : cell occupancy, READ_LAT cycles after address
//   board_rx, board_ry          : RAM read address (column, row)
//   draw_start                  : one-cycle painter kick
//   draw_x0, draw_y0, draw_color: box origin in pixels and its color
//   painter_busy, painter_done  : painter status and completion pulse
//   busy, done                  : scan in progress / scan complete pulse
//   cells_drawn                 : kicks issued in the last scan
module board_redraw
  import tetris_pkg::*;
#(
  parameter int         READ_LAT   = 1,
  parameter bit         DRAW_EMPTY = 1'b1,
  parameter logic [8:0] FILL_COLOR = COLOR_FILL,
  parameter logic [8:0] BG_COLOR   = COLOR_BG
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       board_rdata,
  output logic [3:0] board_rx,
  output logic [4:0] board_ry,
  output logic       draw_start,
  output logic [9:0] draw_x0,
  output logic [8:0] draw_y0,
  output logic [8:0] draw_color,
  input  logic       painter_busy,
  input  logic       painter_done,
  output logic       busy,
  output logic       done,
  output logic [7:0] cells_drawn
);

  // Final WAIT count; only meaningful when READ_LAT > 1.
  localparam logic [1:0] WAIT_END = 2'((READ_LAT > 1) ? READ_LAT - 2 : 0);

  redraw_state_t state, state_nx;
  logic [1:0]    wait_cnt;
  logic          scan_clr, scan_adv, scan_last;
  logic          kick_fire, paint_ack, load_cell, cell_draw;

  board_scan_counter u_scan (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clr      (scan_clr),
    .adv      (scan_adv),
    .x        (board_rx),
    .y        (board_ry),
    .last     (scan_last)
  );

  assign cell_draw = board_rdata || DRAW_EMPTY;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RD;
      ST_RD:    state_nx = (READ_LAT > 1) ? ST_WAIT : ST_CHECK;
      ST_WAIT:  if (wait_cnt == WAIT_END) state_nx = ST_CHECK;
      ST_CHECK: begin
        if (cell_draw)      state_nx = ST_KICK;
        else if (scan_last) state_nx = ST_FIN;
        else                state_nx = ST_RD;
      end
      ST_KICK:  if (!painter_busy) state_nx = ST_PAINT;
      // draw_start is high in the first PAINT cycle; a done seen then
      // belongs to an earlier box, not the one just kicked.
      ST_PAINT: if (painter_done && !draw_start)
                  state_nx = scan_last ? ST_FIN : ST_RD;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    scan_clr  = (state == ST_IDLE) && start;
    kick_fire = (state == ST_KICK) && !painter_busy;
    paint_ack = (state == ST_PAINT) && painter_done && !draw_start;
    load_cell = (state == ST_CHECK) && cell_draw;
    scan_adv  = !scan_last && (((state == ST_CHECK) && !cell_draw) || paint_ack);
  end

  // done is registered from FIN, so busy (from next state) drops with it.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      draw_start  <= 1'b0;
      draw_x0     <= '0;
      draw_y0     <= '0;
      draw_color  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cells_drawn <= '0;
    end else begin
      draw_start <= kick_fire;
      done       <= (state == ST_FIN);
      busy       <= (state_nx != ST_IDLE);
      if (scan_clr)
        cells_drawn <= '0;
      else if (kick_fire)
        cells_drawn <= cells_drawn + 8'd1;
      if (load_cell) begin
        draw_x0    <= {board_rx, 6'b0};
        draw_y0    <= {board_ry, 4'b0} + {1'b0, board_ry, 3'b0};
        draw_color <= board_rdata ? FILL_COLOR : BG_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_board_redraw.sv
// tb/tb_board_redraw.sv - self-checking bench for board_redraw
module tb_board_redraw;
  import tetris_pkg::*;

  localparam int NI = 3;

  logic       clk = 1'b0;
  always #10 clk = ~clk;

  logic       rstn [NI];
  logic       start [NI];
  logic       rdata [NI];
  logic [3:0] rx [NI];
  logic [4:0] ry [NI];
  logic       dstart [NI];
  logic [9:0] x0 [NI];
  logic [8:0] y0 [NI];
  logic [8:0] col [NI];
  logic       pbusy [NI];
  logic       pdone [NI];
  logic       busy [NI];
  logic       done [NI];
  logic [7:0] cells [NI];
  logic       ram [NI][200];
  logic       force_busy [NI];
  logic       inj_done [NI];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int RL = (g == 2) ? 3 : 1;
      localparam bit DE = (g == 1);
      logic [2:0] pipe;
      int         p_cnt;
      logic       p_done;

      board_redraw #(.READ_LAT(RL), .DRAW_EMPTY(DE)) u_dut (
        .CLOCK_50     (clk),
        .resetn       (rstn[g]),
        .start        (start[g]),
        .board_rdata  (rdata[g]),
        .board_rx     (rx[g]),
        .board_ry     (ry[g]),
        .draw_start   (dstart[g]),
        .draw_x0      (x0[g]),
        .draw_y0      (y0[g]),
        .draw_color   (col[g]),
        .painter_busy (pbusy[g]),
        .painter_done (pdone[g]),
        .busy         (busy[g]),
        .done         (done[g]),
        .cells_drawn  (cells[g])
      );

      always @(posedge clk) begin
        pipe <= {pipe[1:0], ram[g][(int'(ry[g]) * 10 + int'(rx[g])) % 200]};
        if (!rstn[g]) begin
          p_cnt  <= 0;
          p_done <= 1'b0;
        end else begin
          p_done <= 1'b0;
          if (p_cnt > 0) begin
            p_cnt <= p_cnt - 1;
            if (p_cnt == 1) p_done <= 1'b1;
          end else if (dstart[g]) begin
            p_cnt <= 10;
          end
        end
      end
      assign rdata[g] = pipe[RL-1];
      assign pbusy[g] = (p_cnt != 0) || force_busy[g];
      assign pdone[g] = p_done || inj_done[g];
    end
  endgenerate

  int vectors = 0;
  int fails = 0;

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, inst, act, exp);
    end
  endtask

  function automatic int rl_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic bit de_of(input int i);
    return (i == 1);
  endfunction

  // Model: a scan is the list of painted cells in row-major order.
  bit scanning [NI];
  bit pending [NI];
  int n_exp [NI], head [NI], kicks [NI], t_start [NI], done_cnt [NI], elapsed [NI];
  int ex_x [NI][200], ex_y [NI][200], ex_c [NI][200];
  int last_x [NI], last_y [NI], last_c [NI];

  task automatic build_exp(input int i);
    n_exp[i] = 0;
    for (int yy = 0; yy < 20; yy++)
      for (int xx = 0; xx < 10; xx++)
        if (ram[i][yy*10+xx] || de_of(i)) begin
          ex_x[i][n_exp[i]] = xx * CELL_W;
          ex_y[i][n_exp[i]] = yy * CELL_H;
          ex_c[i][n_exp[i]] = ram[i][yy*10+xx] ? int'(COLOR_FILL) : int'(COLOR_BG);
          n_exp[i]++;
        end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rstn[i]) begin
        scanning[i] = 1'b0;
        pending[i]  = 1'b0;
        n_exp[i]    = 0;
        head[i]     = 0;
      end else begin
        if (pending[i]) begin
          pending[i]  = 1'b0;
          scanning[i] = 1'b1;
        end
        if (done[i]) begin
          chk("done_in_scan", i, int'(scanning[i]), 1);
          chk("done_all_kicked", i, head[i], n_exp[i]);
          chk("done_cells", i, int'(cells[i]), kicks[i]);
          elapsed[i] = cyc - t_start[i];
          if (n_exp[i] == 0) chk("done_latency", i, elapsed[i], 200 * (rl_of(i) + 1) + 1);
          done_cnt[i]++;
          scanning[i] = 1'b0;
        end
        chk("busy", i, int'(busy[i]), int'(scanning[i]));
        if (dstart[i]) begin
          chk("kick_while_busy", i, int'(pbusy[i]), 0);
          chk("kick_in_range", i, int'(head[i] < n_exp[i]), 1);
          if (head[i] < n_exp[i]) begin
            chk("kick_x0", i, int'(x0[i]), ex_x[i][head[i]]);
            chk("kick_y0", i, int'(y0[i]), ex_y[i][head[i]]);
            chk("kick_color", i, int'(col[i]), ex_c[i][head[i]]);
          end
          last_x[i] = int'(x0[i]);
          last_y[i] = int'(y0[i]);
          last_c[i] = int'(col[i]);
          head[i]++;
          kicks[i]++;
        end
        if (start[i] && !scanning[i] && !pending[i]) begin
          pending[i] = 1'b1;
          build_exp(i);
          head[i]    = 0;
          kicks[i]   = 0;
          t_start[i] = cyc + 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick(1);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int  b;
    bit  ok;
    b  = done_cnt[i];
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt[i] != b) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout_done", i, 0, 1);
    tick(1);
  endtask

  task automatic wait_kicks(input int i, input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (kicks[i] >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout_kick", i, kicks[i], n);
  endtask

  task automatic chk_zero(input string nm, input int i);
    chk({nm, "_draw_start"}, i, int'(dstart[i]), 0);
    chk({nm, "_x0"}, i, int'(x0[i]), 0);
    chk({nm, "_y0"}, i, int'(y0[i]), 0);
    chk({nm, "_color"}, i, int'(col[i]), 0);
    chk({nm, "_busy"}, i, int'(busy[i]), 0);
    chk({nm, "_done"}, i, int'(done[i]), 0);
    chk({nm, "_cells"}, i, int'(cells[i]), 0);
    chk({nm, "_rx"}, i, int'(rx[i]), 0);
    chk({nm, "_ry"}, i, int'(ry[i]), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc;
    for (int i = 0; i < NI; i++) begin
      rstn[i] = 1'b0;
      start[i] = 1'b0;
      force_busy[i] = 1'b0;
      inj_done[i] = 1'b0;
      for (int k = 0; k < 200; k++) ram[i][k] = 1'b0;
    end
    tick(3);
    chk_zero("reset", 0);
    for (int i = 0; i < NI; i++) rstn[i] = 1'b1;
    tick(2);

    // Empty board, skip empties: no kicks, done 401 cycles after start edge.
    pulse_start(0);
    tick(20);
    inj_done[0] = 1'b1;
    tick(1);
    inj_done[0] = 1'b0;
    wait_done(0, 1000);
    chk("t1_kicks", 0, kicks[0], 0);
    chk("t1_latency", 0, elapsed[0], 401);
    chk("t1_cells", 0, int'(cells[0]), 0);

    // Only the last cell filled.
    ram[0][199] = 1'b1;
    pulse_start(0);
    wait_done(0, 1000);
    chk("t2_kicks", 0, kicks[0], 1);
    chk("t2_x0", 0, last_x[0], 576);
    chk("t2_y0", 0, last_y[0], 456);
    chk("t2_color", 0, last_c[0], 9'b111000111);
    chk("t2_cells", 0, int'(cells[0]), 1);

    // Painter busy held across KICK; extra starts are ignored.
    ram[0][199] = 1'b0;
    ram[0][12]  = 1'b1;
    force_busy[0] = 1'b1;
    pulse_start(0);
    tick(10);
    pulse_start(0);
    tick(60);
    pulse_start(0);
    tick(5);
    chk("t3_withheld", 0, kicks[0], 0);
    force_busy[0] = 1'b0;
    wait_done(0, 1000);
    chk("t3_kicks", 0, kicks[0], 1);
    chk("t3_x0", 0, last_x[0], 128);
    chk("t3_y0", 0, last_y[0], 24);
    chk("t3_cells", 0, int'(cells[0]), 1);

    // Checkerboard, empties painted: 200 kicks with alternating colors.
    for (int k = 0; k < 200; k++) ram[1][k] = (((k / 10) + (k % 10)) % 2 == 0);
    pulse_start(1);
    wait_done(1, 6000);
    chk("t4_kicks", 1, kicks[1], 200);
    chk("t4_cells", 1, int'(cells[1]), 200);
    chk("t4_last_x0", 1, last_x[1], 576);
    chk("t4_last_y0", 1, last_y[1], 456);
    chk("t4_last_color", 1, last_c[1], 9'b111000111);

    // Reset at the 37th kick: outputs clear, no done, fresh scan from (0,0).
    pulse_start(1);
    wait_kicks(1, 37, 3000);
    chk("t5_x0_before", 1, last_x[1], 384);
    rstn[1] = 1'b0;
    #1;
    chk_zero("t5_abort", 1);
    tick(3);
    rstn[1] = 1'b1;
    dc = done_cnt[1];
    tick(600);
    chk("t5_no_done", 1, done_cnt[1], dc);
    pulse_start(1);
    wait_kicks(1, 1, 100);
    chk("t5_first_x0", 1, last_x[1], 0);
    chk("t5_first_y0", 1, last_y[1], 0);
    chk("t5_first_color", 1, last_c[1], 9'b111000111);
    wait_done(1, 6000);
    chk("t5_cells", 1, int'(cells[1]), 200);

    // Three-cycle read latency.
    pulse_start(2);
    wait_done(2, 2000);
    chk("t6_latency", 2, elapsed[2], 801);
    chk("t6_kicks", 2, kicks[2], 0);
    ram[2][3] = 1'b1;
    pulse_start(2);
    wait_done(2, 2000);
    chk("t6b_kicks", 2, kicks[2], 1);
    chk("t6b_x0", 2, last_x[2], 192);
    chk("t6b_y0", 2, last_y[2], 0);
    chk("t6b_color", 2, last_c[2], 9'b111000111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
